// File: rtl/axi_burst_master_if.sv
// AXI4 master-side bus (AR/R/AW/W/B) between axi_burst_master and its slave.
// Every channel transfers on a cycle where valid and ready are both high at the rising clock edge.
interface axi_burst_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;

  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 INCR burst master: turns one core request into one AR/R or AW/W/B
// transaction, rejects bursts crossing a 4 KB page, and reports a one-cycle completion pulse.
module axi_burst_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int ID_VAL = 0,
  parameter int LEN_W  = 4
) (
  input  logic                ACLK,
  input  logic                ARESETn,

  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [LEN_W-1:0]    req_len,
  input  logic [DATA_W/8-1:0] req_strb,

  input  logic                wdata_valid,
  output logic                wdata_ready,
  input  logic [DATA_W-1:0]   wdata,

  output logic                rdata_valid,
  input  logic                rdata_ready,
  output logic [DATA_W-1:0]   rdata,
  output logic                rdata_last,

  output logic                resp_valid,
  output logic                resp_err,

  output logic [2:0]          dbg_state,

  axi_burst_master_if.master  axi
);

  localparam int         BYTES = DATA_W / 8;
  localparam int         SUM_W = LEN_W + 17;
  localparam logic [2:0] SIZE  = (DATA_W == 64) ? 3'd3 : 3'd2;

  // DONE is the normal completion slot; ERRDONE is reserved for rejected requests.
  typedef enum logic [2:0] {
    IDLE, RADDR, RDATA, WADDR, WDATA, WRESP, ERRDONE, DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [LEN_W-1:0]    len_q;
  logic [DATA_W/8-1:0] strb_q;
  logic [LEN_W-1:0]    cnt_q;
  logic                err_q;

  logic                accept, crosses, last_beat, r_hs, w_hs;
  logic [SUM_W-1:0]    end_off;

  // Burst end offset within the page; exactly 4096 ends on the boundary and is legal.
  assign end_off   = SUM_W'(req_addr[11:0]) + (SUM_W'(req_len) + SUM_W'(1)) * SUM_W'(BYTES);
  assign crosses   = end_off > SUM_W'(4096);
  assign accept    = req_valid && req_ready;
  assign last_beat = (cnt_q == len_q);
  assign r_hs      = axi.rvalid && axi.rready;
  assign w_hs      = axi.wvalid && axi.wready;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = crosses ? ERRDONE : (req_write ? WADDR : RADDR);
      RADDR:   if (axi.arready) state_d = RDATA;
      RDATA:   if (r_hs && axi.rlast) state_d = DONE;
      WADDR:   if (axi.awready) state_d = WDATA;
      WDATA:   if (w_hs && last_beat) state_d = WRESP;
      WRESP:   if (axi.bvalid) state_d = DONE;
      ERRDONE: state_d = IDLE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      addr_q <= '0;
      len_q  <= '0;
      strb_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (accept) begin
        addr_q <= req_addr;
        len_q  <= req_len;
        strb_q <= req_strb;
        err_q  <= 1'b0;
      end
      if ((state_q == RADDR && axi.arready) || (state_q == WADDR && axi.awready))
        cnt_q <= '0;
      else if (r_hs || w_hs)
        cnt_q <= cnt_q + 1'b1;
      // A beat is malformed if RLAST and "counter reached len" disagree.
      if (r_hs && ((axi.rresp != 2'b00) || (axi.rlast != last_beat)))
        err_q <= 1'b1;
      if (state_q == WRESP && axi.bvalid && axi.bresp != 2'b00)
        err_q <= 1'b1;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign dbg_state = state_q;

  assign axi.arvalid = (state_q == RADDR);
  assign axi.araddr  = axi.arvalid ? addr_q          : '0;
  assign axi.arlen   = axi.arvalid ? 8'(len_q)       : '0;
  assign axi.arsize  = axi.arvalid ? SIZE            : '0;
  assign axi.arburst = axi.arvalid ? 2'b01           : '0;
  assign axi.arid    = axi.arvalid ? ID_W'(ID_VAL)   : '0;

  assign axi.awvalid = (state_q == WADDR);
  assign axi.awaddr  = axi.awvalid ? addr_q          : '0;
  assign axi.awlen   = axi.awvalid ? 8'(len_q)       : '0;
  assign axi.awsize  = axi.awvalid ? SIZE            : '0;
  assign axi.awburst = axi.awvalid ? 2'b01           : '0;
  assign axi.awid    = axi.awvalid ? ID_W'(ID_VAL)   : '0;

  assign axi.rready  = (state_q == RDATA) && rdata_ready;
  assign rdata_valid = (state_q == RDATA) && axi.rvalid;
  assign rdata       = axi.rdata;
  assign rdata_last  = axi.rlast;

  assign axi.wvalid  = (state_q == WDATA) && wdata_valid;
  assign wdata_ready = (state_q == WDATA) && axi.wready;
  assign axi.wdata   = (state_q == WDATA) ? wdata  : '0;
  assign axi.wstrb   = (state_q == WDATA) ? strb_q : '0;
  assign axi.wlast   = (state_q == WDATA) && last_beat;

  assign axi.bready  = (state_q == WRESP);

  assign resp_valid  = (state_q == DONE) || (state_q == ERRDONE);
  assign resp_err    = (state_q == ERRDONE) || ((state_q == DONE) && err_q);

endmodule

// File: tb/tb_axi_burst_master.sv
// Scenario bench for axi_burst_master: an inline AXI slave model plus read/write data scoreboards.
module tb_axi_burst_master;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;
  localparam int ID_VAL = 5;
  localparam int LEN_W  = 4;

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;

  logic                req_valid, req_ready, req_write;
  logic [ADDR_W-1:0]   req_addr;
  logic [LEN_W-1:0]    req_len;
  logic [DATA_W/8-1:0] req_strb;
  logic                wdata_valid, wdata_ready;
  logic [DATA_W-1:0]   wdata;
  logic                rdata_valid, rdata_ready, rdata_last;
  logic [DATA_W-1:0]   rdata;
  logic                resp_valid, resp_err;
  logic [2:0]          dbg_state;

  axi_burst_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) axi ();

  axi_burst_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .ID_VAL(ID_VAL), .LEN_W(LEN_W)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_strb(req_strb),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata), .rdata_last(rdata_last),
    .resp_valid(resp_valid), .resp_err(resp_err),
    .dbg_state(dbg_state),
    .axi(axi)
  );

  int errors = 0;
  int checks = 0;

  logic [DATA_W:0]   exp_q[$];
  logic [DATA_W-1:0] wexp_q[$];

  int   o_beats, o_resp_cyc, o_last_hs_cyc;
  logic o_resp_err;
  bit   o_resp_seen, o_ax_seen, o_ready_at_req, o_resp_at_req, o_ready_in_resp;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    req_valid = 0; req_write = 0; req_addr = '0; req_len = '0; req_strb = '0;
    wdata_valid = 0; wdata = '0; rdata_ready = 0;
    axi.arready = 1; axi.awready = 1;
    axi.rid = '0; axi.rdata = '0; axi.rresp = 2'b00; axi.rlast = 0; axi.rvalid = 0;
    axi.wready = 0;
    axi.bid = '0; axi.bresp = 2'b00; axi.bvalid = 0;
  endtask

  // Drives one request and plays the slave until the completion pulse or a cycle budget expires.
  task automatic do_txn(input logic wr, input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len,
                        input logic [DATA_W/8-1:0] strb, input int wstall, input int rlast_beat,
                        input int err_beat, input logic [1:0] bresp);
    int rk, wj, stall;
    bit ar_done, aw_done, w_done, r_done, b_done, r_shown, w_shown;
    logic [DATA_W-1:0] val;
    logic [DATA_W:0] exp;
    rk = 0; wj = 0; stall = 0;
    ar_done = 0; aw_done = 0; w_done = 0; r_done = 0; b_done = 0; r_shown = 0; w_shown = 0;
    o_beats = 0; o_resp_cyc = -1; o_last_hs_cyc = -100; o_resp_err = 1'bx;
    o_resp_seen = 0; o_ax_seen = 0; o_ready_in_resp = 0;
    exp_q.delete(); wexp_q.delete();

    @(negedge ACLK);
    req_valid = 1; req_write = wr; req_addr = addr; req_len = len; req_strb = strb;
    #1;
    o_ready_at_req = req_ready;
    o_resp_at_req  = resp_valid;

    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge ACLK);
      req_valid = 0;
      if (ar_done && !r_done) begin
        if (!r_shown) begin
          val = $urandom;
          axi.rdata = val;
          axi.rlast = (rk == rlast_beat);
          axi.rresp = (rk == err_beat) ? 2'b10 : 2'b00;
          axi.rvalid = 1;
          exp_q.push_back({axi.rlast, val});
          r_shown = 1;
        end
      end else begin
        axi.rvalid = 0; axi.rlast = 0;
      end
      rdata_ready = ($urandom_range(0, 3) != 0);
      if (aw_done && !w_done) begin
        if (!w_shown) begin
          val = $urandom;
          wdata = val; wdata_valid = 1;
          wexp_q.push_back(val);
          w_shown = 1;
        end
        axi.wready = (stall >= wstall);
        stall++;
      end else begin
        wdata_valid = 0; axi.wready = 0;
      end
      axi.bvalid = w_done && !b_done;
      axi.bresp  = bresp;
      #1;

      if (axi.arvalid) begin
        o_ax_seen = 1; ar_done = 1; checks++;
        if ({axi.araddr, axi.arlen, axi.arsize, axi.arburst, axi.arid} !==
            {addr, 8'(len), 3'd2, 2'b01, 4'(ID_VAL)}) begin
          errors++;
          $display("FAIL ar_fields: got addr=%h len=%0d size=%0d burst=%0d id=%0d want addr=%h len=%0d size=2 burst=1 id=%0d",
                   axi.araddr, axi.arlen, axi.arsize, axi.arburst, axi.arid, addr, len, ID_VAL);
        end
      end
      if (axi.awvalid) begin
        o_ax_seen = 1; aw_done = 1; checks++;
        if ({axi.awaddr, axi.awlen, axi.awsize, axi.awburst, axi.awid} !==
            {addr, 8'(len), 3'd2, 2'b01, 4'(ID_VAL)}) begin
          errors++;
          $display("FAIL aw_fields: got addr=%h len=%0d size=%0d burst=%0d id=%0d want addr=%h len=%0d",
                   axi.awaddr, axi.awlen, axi.awsize, axi.awburst, axi.awid, addr, len);
        end
      end
      if (r_shown) begin
        checks++;
        if ({rdata_valid, axi.rready} !== {1'b1, rdata_ready}) begin
          errors++;
          $display("FAIL r_handshake: rdata_valid=%b rready=%b want 1 %b", rdata_valid, axi.rready, rdata_ready);
        end
        if (rdata_valid && rdata_ready) begin
          exp = exp_q.pop_front();
          checks++;
          if ({rdata_last, rdata} !== exp) begin
            errors++;
            $display("FAIL rdata_beat%0d: got last=%b data=%h want last=%b data=%h",
                     rk, rdata_last, rdata, exp[DATA_W], exp[DATA_W-1:0]);
          end
          o_beats++; rk++; r_shown = 0;
          if (exp[DATA_W]) begin r_done = 1; o_last_hs_cyc = cyc; end
        end
      end
      if (w_shown) begin
        checks++;
        if ({axi.wvalid, axi.wdata, axi.wstrb, axi.wlast, wdata_ready} !==
            {1'b1, wexp_q[0], strb, (wj == int'(len)), axi.wready}) begin
          errors++;
          $display("FAIL w_beat%0d: got valid=%b data=%h strb=%h last=%b wdata_ready=%b want 1 %h %h %b %b",
                   wj, axi.wvalid, axi.wdata, axi.wstrb, axi.wlast, wdata_ready,
                   wexp_q[0], strb, (wj == int'(len)), axi.wready);
        end
        if (axi.wready) begin
          void'(wexp_q.pop_front());
          o_beats++; w_shown = 0;
          if (wj == int'(len)) w_done = 1;
          wj++;
        end
      end
      if (axi.bvalid) begin
        checks++;
        if (axi.bready !== 1'b1) begin
          errors++;
          $display("FAIL bready: got %b want 1", axi.bready);
        end
        b_done = 1; o_last_hs_cyc = cyc;
      end
      if (resp_valid) begin
        o_resp_seen = 1; o_resp_cyc = cyc; o_resp_err = resp_err; o_ready_in_resp = req_ready;
        break;
      end
    end
    axi.rvalid = 0; axi.rlast = 0; axi.bvalid = 0; wdata_valid = 0; axi.wready = 0;

    checks++;
    if (!o_resp_seen || exp_q.size() != 0) begin
      errors++;
      $display("FAIL completion: resp_seen=%b leftover_r=%0d want resp_seen=1 leftover_r=0",
               o_resp_seen, exp_q.size());
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    ARESETn = 0;
    #12;
    checks++;
    if ({req_ready, axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready,
         resp_valid, rdata_valid, wdata_ready} !== 9'b1_0000_0000) begin
      errors++;
      $display("FAIL reset_ctrl: got rr=%b arv=%b awv=%b wv=%b rrdy=%b brdy=%b rv=%b rdv=%b wdr=%b want 1 then zeros",
               req_ready, axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready,
               resp_valid, rdata_valid, wdata_ready);
    end
    checks++;
    if ({dbg_state, axi.araddr, axi.awaddr, axi.wdata, axi.wstrb} !== '0) begin
      errors++;
      $display("FAIL reset_data: state=%0d araddr=%h awaddr=%h wdata=%h wstrb=%h want all 0",
               dbg_state, axi.araddr, axi.awaddr, axi.wdata, axi.wstrb);
    end
    @(negedge ACLK);
    ARESETn = 1;
  endtask

  task automatic test_read_burst();
    do_txn(1'b0, 32'h1000, 4'd3, 4'hF, 0, 3, -1, 2'b00);
    checks++;
    if ({o_ready_at_req, o_resp_err} !== 2'b10 || o_beats != 4 || o_resp_cyc != o_last_hs_cyc + 1) begin
      errors++;
      $display("FAIL read_burst: ready=%b err=%b beats=%0d resp_cyc=%0d last_hs=%0d want 1 0 4 last_hs+1",
               o_ready_at_req, o_resp_err, o_beats, o_resp_cyc, o_last_hs_cyc);
    end
  endtask

  task automatic test_write_stall();
    do_txn(1'b1, 32'h2000, 4'd1, 4'hF, 2, -1, -1, 2'b00);
    checks++;
    if (o_resp_err !== 1'b0 || o_beats != 2 || o_resp_cyc != o_last_hs_cyc + 1) begin
      errors++;
      $display("FAIL write_stall: err=%b beats=%0d resp_cyc=%0d last_hs=%0d want 0 2 last_hs+1",
               o_resp_err, o_beats, o_resp_cyc, o_last_hs_cyc);
    end
    do_txn(1'b1, 32'h2100, 4'd4, 4'h6, 1, -1, -1, 2'b00);
    checks++;
    if (o_resp_err !== 1'b0 || o_beats != 5) begin
      errors++;
      $display("FAIL write_strb6: err=%b beats=%0d want 0 5", o_resp_err, o_beats);
    end
  endtask

  task automatic test_boundary();
    do_txn(1'b0, 32'h0FF8, 4'd3, 4'hF, 0, 3, -1, 2'b00);
    checks++;
    if (o_ax_seen || o_resp_err !== 1'b1 || o_resp_cyc > 2) begin
      errors++;
      $display("FAIL boundary_read: ax_seen=%b err=%b resp_cyc=%0d want 0 1 <=2", o_ax_seen, o_resp_err, o_resp_cyc);
    end
    do_txn(1'b1, 32'h1FFC, 4'd1, 4'hF, 0, -1, -1, 2'b00);
    checks++;
    if (o_ax_seen || o_resp_err !== 1'b1 || o_resp_cyc > 2) begin
      errors++;
      $display("FAIL boundary_write: ax_seen=%b err=%b resp_cyc=%0d want 0 1 <=2", o_ax_seen, o_resp_err, o_resp_cyc);
    end
    do_txn(1'b0, 32'h0FF0, 4'd3, 4'hF, 0, 3, -1, 2'b00);
    checks++;
    if (!o_ax_seen || o_resp_err !== 1'b0 || o_beats != 4) begin
      errors++;
      $display("FAIL boundary_exact: ax_seen=%b err=%b beats=%0d want 1 0 4", o_ax_seen, o_resp_err, o_beats);
    end
  endtask

  task automatic test_read_errors();
    do_txn(1'b0, 32'h4000, 4'd3, 4'hF, 0, 1, -1, 2'b00);
    checks++;
    if (o_resp_err !== 1'b1 || o_beats != 2 || o_resp_cyc != o_last_hs_cyc + 1) begin
      errors++;
      $display("FAIL early_rlast: err=%b beats=%0d resp_cyc=%0d last_hs=%0d want 1 2 last_hs+1",
               o_resp_err, o_beats, o_resp_cyc, o_last_hs_cyc);
    end
    do_txn(1'b0, 32'h4100, 4'd3, 4'hF, 0, 3, 2, 2'b00);
    checks++;
    if (o_resp_err !== 1'b1 || o_beats != 4) begin
      errors++;
      $display("FAIL rresp_slverr: err=%b beats=%0d want 1 4", o_resp_err, o_beats);
    end
    do_txn(1'b0, 32'h4200, 4'd1, 4'hF, 0, 2, -1, 2'b00);
    checks++;
    if (o_resp_err !== 1'b1 || o_beats != 3) begin
      errors++;
      $display("FAIL late_rlast: err=%b beats=%0d want 1 3", o_resp_err, o_beats);
    end
  endtask

  task automatic test_back_to_back();
    bit ready_in_first;
    do_txn(1'b1, 32'h5000, 4'd2, 4'hC, 0, -1, -1, 2'b10);
    ready_in_first = o_ready_in_resp;
    checks++;
    if (o_resp_err !== 1'b1 || ready_in_first) begin
      errors++;
      $display("FAIL b2b_write: err=%b req_ready_during_resp=%b want 1 0", o_resp_err, ready_in_first);
    end
    do_txn(1'b0, 32'h5100, 4'd0, 4'hF, 0, 0, -1, 2'b00);
    checks++;
    if ({o_ready_at_req, o_resp_at_req, o_resp_err} !== 3'b100 || o_beats != 1) begin
      errors++;
      $display("FAIL b2b_read: ready=%b resp_still=%b err=%b beats=%0d want 1 0 0 1",
               o_ready_at_req, o_resp_at_req, o_resp_err, o_beats);
    end
  endtask

  task automatic test_reset_mid_burst();
    int whs;
    bit hit, resp_seen;
    whs = 0; hit = 0; resp_seen = 0;
    @(negedge ACLK);
    req_valid = 1; req_write = 1; req_addr = 32'h3000; req_len = 4'd3; req_strb = 4'h3;
    @(negedge ACLK);
    req_valid = 0; wdata_valid = 1; axi.wready = 1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge ACLK);
      wdata = $urandom;
      #1;
      if (axi.wvalid && whs == 2) begin
        #2;
        ARESETn = 0;
        #1;
        hit = 1;
        break;
      end
      if (axi.wvalid && axi.wready) whs++;
    end
    checks++;
    if (!hit || {axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready,
                 resp_valid, wdata_ready, req_ready} !== 8'b0000_0001 || dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_mid: hit=%b arv=%b awv=%b wv=%b rrdy=%b brdy=%b rv=%b wdr=%b rr=%b state=%0d want 1 0s rr=1 state=0",
               hit, axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready,
               resp_valid, wdata_ready, req_ready, dbg_state);
    end
    idle_inputs();
    @(negedge ACLK);
    @(negedge ACLK);
    ARESETn = 1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge ACLK);
      #1;
      if (resp_valid) resp_seen = 1;
    end
    checks++;
    if (resp_seen || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_no_resp: resp_seen=%b req_ready=%b want 0 1", resp_seen, req_ready);
    end
    do_txn(1'b0, 32'h6000, 4'd2, 4'hF, 0, 2, -1, 2'b00);
    checks++;
    if (o_resp_err !== 1'b0 || o_beats != 3) begin
      errors++;
      $display("FAIL after_reset_read: err=%b beats=%0d want 0 3", o_resp_err, o_beats);
    end
  endtask

  initial begin
    test_reset();
    test_read_burst();
    test_write_stall();
    test_boundary();
    test_read_errors();
    test_back_to_back();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
